// File: rtl/model_test_mul_arb_pkg.sv
// Shared defaults, transaction types and the round-robin pick function for the
// time-shared signed multiplier.
package model_test_mul_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned A_W     = 12;
    localparam int unsigned B_W     = 7;
    localparam int unsigned P_W     = 18;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned PTR_W   = 3;

    typedef struct packed {
        logic signed [A_W-1:0] a;
        logic signed [B_W-1:0] b;
        logic [ID_W-1:0]       id;
    } mul_req_t;

    typedef struct packed {
        logic signed [P_W-1:0] p;
        logic [ID_W-1:0]       id;
    } mul_rsp_t;

    // One-hot grant of the first valid requester at or after ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input logic [PTR_W-1:0]   ptr,
                                                   input int unsigned        n);
        logic [MAX_REQ-1:0] grant;
        logic               found;
        logic [PTR_W-1:0]   idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = PTR_W'((32'(ptr) + k) % n);
                if (!found && valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/model_test_mul_share_arb_if.sv
// Request/response bundle of the shared multiplier: per-requester operands with
// valid/ready, and a single tagged result stream.
interface model_test_mul_share_arb_if #(
    parameter int unsigned NUM_REQ = model_test_mul_arb_pkg::NUM_REQ,
    parameter int unsigned A_W     = model_test_mul_arb_pkg::A_W,
    parameter int unsigned B_W     = model_test_mul_arb_pkg::B_W,
    parameter int unsigned P_W     = model_test_mul_arb_pkg::P_W,
    parameter int unsigned ID_W    = model_test_mul_arb_pkg::ID_W
);

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [P_W-1:0]         rsp_p;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );

endinterface

// File: rtl/model_test_mul_pipe.sv
// Enable-gated signed multiply with MUL_STAGES product registers; the last stage is
// the registered result. MODEL_TEST_MUL_ARB_SAT_EN selects saturation instead of wrap.
module model_test_mul_pipe #(
    parameter int unsigned A_W        = 12,
    parameter int unsigned B_W        = 7,
    parameter int unsigned P_W        = 18,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned MUL_STAGES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  in_valid_i,
    input  logic signed [A_W-1:0] in_a_i,
    input  logic signed [B_W-1:0] in_b_i,
    input  logic [ID_W-1:0]       in_id_i,
    output logic                  out_valid_o,
    output logic [ID_W-1:0]       out_id_o,
    output logic [P_W-1:0]        out_p_o
);

    localparam int unsigned FW = A_W + B_W;

    logic [P_W-1:0] prod;

`ifdef MODEL_TEST_MUL_ARB_SAT_EN
    localparam logic signed [FW-1:0] PMax = {{(FW-P_W+1){1'b0}}, {(P_W-1){1'b1}}};
    localparam logic signed [FW-1:0] PMin = {{(FW-P_W+1){1'b1}}, {(P_W-1){1'b0}}};

    logic signed [FW-1:0] full;

    always_comb begin
        full = FW'(in_a_i) * FW'(in_b_i);
        if (full > PMax) begin
            prod = {1'b0, {(P_W-1){1'b1}}};
        end else if (full < PMin) begin
            prod = {1'b1, {(P_W-1){1'b0}}};
        end else begin
            prod = full[P_W-1:0];
        end
    end
`else
    always_comb begin
        prod = P_W'(FW'(in_a_i) * FW'(in_b_i));
    end
`endif

    logic            vld_d [MUL_STAGES];
    logic            vld_q [MUL_STAGES];
    logic [ID_W-1:0] id_d  [MUL_STAGES];
    logic [ID_W-1:0] id_q  [MUL_STAGES];
    logic [P_W-1:0]  p_d   [MUL_STAGES];
    logic [P_W-1:0]  p_q   [MUL_STAGES];

    always_comb begin
        vld_d = vld_q;
        id_d  = id_q;
        p_d   = p_q;
        if (en_i) begin
            vld_d[0] = in_valid_i;
            id_d[0]  = in_id_i;
            p_d[0]   = prod;
            for (int s = 1; s < MUL_STAGES; s++) begin
                vld_d[s] = vld_q[s-1];
                id_d[s]  = id_q[s-1];
                p_d[s]   = p_q[s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < MUL_STAGES; s++) begin
                vld_q[s] <= 1'b0;
                id_q[s]  <= '0;
                p_q[s]   <= '0;
            end
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
            p_q   <= p_d;
        end
    end

    assign out_valid_o = vld_q[MUL_STAGES-1];
    assign out_id_o    = id_q[MUL_STAGES-1];
    assign out_p_o     = p_q[MUL_STAGES-1];

endmodule

// File: rtl/model_test_mul_share_arb.sv
// Round-robin arbiter sharing one signed multiplier among NUM_REQ requesters, with a
// tagged result stream. Build with MODEL_TEST_MUL_ARB_SAT_EN for saturating products.
module model_test_mul_share_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned A_W        = 12,
    parameter int unsigned B_W        = 7,
    parameter int unsigned P_W        = 18,
    parameter int unsigned MUL_STAGES = 1,
    parameter int unsigned ID_W       = 2
) (
    input logic                       ap_clk,
    input logic                       ap_rst,
    model_test_mul_share_arb_if.slave bus
);

    import model_test_mul_arb_pkg::*;

    logic                  advance;
    logic                  accept;
    logic                  rsp_vld;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       gnt_idx;
    logic signed [A_W-1:0] a_sel;
    logic signed [B_W-1:0] b_sel;

    logic [ID_W-1:0]       rr_ptr_d, rr_ptr_q;
    logic                  op_vld_d, op_vld_q;
    logic signed [A_W-1:0] op_a_d, op_a_q;
    logic signed [B_W-1:0] op_b_d, op_b_q;
    logic [ID_W-1:0]       op_id_d, op_id_q;

    // Whole pipeline moves as one; a stalled full output freezes every stage.
    assign advance = !rsp_vld || bus.rsp_ready;

    always_comb begin
        grant = '0;
        if (!ap_rst && advance) begin
            grant = NUM_REQ'(rr_pick(MAX_REQ'(bus.req_valid), PTR_W'(rr_ptr_q), NUM_REQ));
        end
    end

    always_comb begin
        gnt_idx = '0;
        a_sel   = '0;
        b_sel   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx = ID_W'(i);
                a_sel   = bus.req_a[i*A_W +: A_W];
                b_sel   = bus.req_b[i*B_W +: B_W];
            end
        end
    end

    assign accept = |grant;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        op_vld_d = op_vld_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_id_d  = op_id_q;
        if (accept) begin
            rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            op_a_d   = a_sel;
            op_b_d   = b_sel;
            op_id_d  = gnt_idx;
        end
        if (advance) begin
            op_vld_d = accept;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rr_ptr_q <= '0;
            op_vld_q <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_id_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            op_vld_q <= op_vld_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_id_q  <= op_id_d;
        end
    end

    model_test_mul_pipe #(
        .A_W       (A_W),
        .B_W       (B_W),
        .P_W       (P_W),
        .ID_W      (ID_W),
        .MUL_STAGES(MUL_STAGES)
    ) u_pipe (
        .clk_i      (ap_clk),
        .rst_i      (ap_rst),
        .en_i       (advance),
        .in_valid_i (op_vld_q),
        .in_a_i     (op_a_q),
        .in_b_i     (op_b_q),
        .in_id_i    (op_id_q),
        .out_valid_o(rsp_vld),
        .out_id_o   (bus.rsp_id),
        .out_p_o    (bus.rsp_p)
    );

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_vld;

endmodule

// File: tb/tb_model_test_mul_share_arb.sv
// Randomized scoreboard bench for model_test_mul_share_arb: a grant/occupancy model
// issues expected results into a queue that an independent monitor drains.
module tb_model_test_mul_share_arb;

    import model_test_mul_arb_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned MS  = 1;
    localparam int unsigned L   = MS + 1;

    logic clk = 1'b0;
    logic ap_rst;

    always #5 clk = ~clk;

    model_test_mul_share_arb_if #(
        .NUM_REQ(N), .A_W(A_W), .B_W(B_W), .P_W(P_W), .ID_W(ID_W)
    ) bus ();

    model_test_mul_share_arb #(
        .NUM_REQ(N), .A_W(A_W), .B_W(B_W), .P_W(P_W), .MUL_STAGES(MS), .ID_W(ID_W)
    ) dut (
        .ap_clk(clk),
        .ap_rst(ap_rst),
        .bus   (bus.slave)
    );

    int       checks   = 0;
    int       failures = 0;
    mul_rsp_t exp_q[$];
    logic     vld [N];
    int       a_v [N];
    int       b_v [N];
    logic     acc [N];
    bit       mv  [L];
    int       ptr;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Expected product from plain integer arithmetic.
    function automatic int model_p(int a, int b);
        int full;
        int lim;
        int w;
        full = a * b;
        lim  = 1 << (P_W - 1);
`ifdef MODEL_TEST_MUL_ARB_SAT_EN
        if (full > lim - 1) return lim - 1;
        if (full < -lim) return -lim;
        w = full;
`else
        w = full & ((1 << P_W) - 1);
        if (w >= lim) w = w - (1 << P_W);
`endif
        return w;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]           = vld[i];
            bus.req_a[i*A_W +: A_W]    = A_W'(a_v[i]);
            bus.req_b[i*B_W +: B_W]    = B_W'(b_v[i]);
        end
    endtask

    task automatic idle();
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0;
            acc[i] = 1'b0;
        end
        drive();
    endtask

    task automatic rand_ops(input int i);
        if ($urandom_range(6) == 0) a_v[i] = ($urandom_range(1) == 0) ? -2048 : 2047;
        else a_v[i] = int'($urandom_range(4095)) - 2048;
        if ($urandom_range(6) == 0) b_v[i] = ($urandom_range(1) == 0) ? -64 : 63;
        else b_v[i] = int'($urandom_range(127)) - 64;
    endtask

    // Requesters hold until accepted; may legally withdraw; keep=1 re-requests at once.
    task automatic next_ops(input logic [N-1:0] mask, input int pct, input bit keep,
                            input int drop_pct);
        for (int i = 0; i < N; i++) begin
            if (acc[i] || !vld[i]) begin
                vld[i] = mask[i] && (keep || int'($urandom_range(99)) < pct);
                if (vld[i]) rand_ops(i);
            end else if (!mask[i] || int'($urandom_range(99)) < drop_pct) begin
                vld[i] = 1'b0;
            end
            acc[i] = 1'b0;
        end
        drive();
    endtask

    // One clock: predict grant and output occupancy, issue expectations, advance model.
    task automatic step();
        int         g;
        int         idx;
        bit         adv;
        logic [N-1:0] exp_rdy;
        mul_rsp_t   e;
        @(negedge clk);
        adv = !mv[L-1] || bus.rsp_ready;
        g   = -1;
        if (!ap_rst && adv) begin
            for (int k = 0; k < N; k++) begin
                idx = (ptr + k) % N;
                if (g < 0 && vld[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", int'(bus.req_ready), int'(exp_rdy));
        chk("rsp_valid", int'(bus.rsp_valid), int'(mv[L-1]));
        if (g >= 0) begin
            e.id = ID_W'(g);
            e.p  = P_W'(model_p(a_v[g], b_v[g]));
            exp_q.push_back(e);
            acc[g] = 1'b1;
            ptr    = (g + 1) % N;
        end
        if (ap_rst) begin
            mv  = '{default: 1'b0};
            ptr = 0;
            exp_q.delete();
        end else if (adv) begin
            for (int s = L - 1; s > 0; s--) mv[s] = mv[s-1];
            mv[0] = (g >= 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        idle();
        bus.rsp_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            step();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        step();
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!ap_rst && bus.rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got id=%0d p=%0d, required no response",
                             bus.rsp_id, $signed(bus.rsp_p));
                end else begin
                    chk("rsp_id", int'(bus.rsp_id), int'(exp_q[0].id));
                    chk("rsp_p", int'($signed(bus.rsp_p)), int'($signed(exp_q[0].p)));
                    if (bus.rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run still active at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] mask;
        ap_rst        = 1'b1;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0; a_v[i] = 0; b_v[i] = 0; acc[i] = 1'b0;
        end
        drive();
        mv  = '{default: 1'b0};
        ptr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
        chk("reset_rsp_id", int'(bus.rsp_id), 0);
        chk("reset_rsp_p", int'(bus.rsp_p), 0);
        for (int i = 0; i < N; i++) vld[i] = 1'b1;
        drive();
        #1;
        chk("reset_req_ready", int'(bus.req_ready), 0);
        idle();
        ap_rst        = 1'b0;
        bus.rsp_ready = 1'b1;

        // Single requester 0, latency and product.
        vld[0] = 1'b1; a_v[0] = 2047; b_v[0] = 63;
        drive();
        step();
        idle();
        step();
        chk("single_valid", int'(bus.rsp_valid), 1);
        chk("single_id", int'(bus.rsp_id), 0);
        chk("single_p", int'($signed(bus.rsp_p)), 128961);
        drain();

        // Requester 2 corner product.
        vld[2] = 1'b1; a_v[2] = -2048; b_v[2] = -64;
        drive();
        step();
        idle();
        step();
        chk("corner_id", int'(bus.rsp_id), 2);
`ifdef MODEL_TEST_MUL_ARB_SAT_EN
        chk("corner_p", int'($signed(bus.rsp_p)), 131071);
`else
        chk("corner_p", int'($signed(bus.rsp_p)), -131072);
`endif
        drain();

        // All four continuously valid: one grant per cycle in rotation.
        repeat (12) begin
            next_ops(4'hF, 100, 1'b1, 0);
            step();
        end
        drain();

        // Requesters 1 and 3 under four cycles of output backpressure.
        next_ops(4'b1010, 100, 1'b1, 0);
        step();
        bus.rsp_ready = 1'b0;
        repeat (4) begin
            next_ops(4'b1010, 100, 1'b1, 0);
            step();
        end
        bus.rsp_ready = 1'b1;
        repeat (3) begin
            next_ops(4'b1010, 100, 1'b1, 0);
            step();
        end
        drain();

        // Reset with operations in flight.
        repeat (2) begin
            next_ops(4'b0011, 100, 1'b1, 0);
            step();
        end
        idle();
        ap_rst        = 1'b1;
        bus.rsp_ready = 1'b0;
        step();
        ap_rst        = 1'b0;
        bus.rsp_ready = 1'b1;
        chk("post_reset_valid", int'(bus.rsp_valid), 0);
        next_ops(4'b0110, 100, 1'b0, 0);
        #1;
        chk("post_reset_grant", int'(bus.req_ready), 2);
        step();
        drain();

        // Requester 0 withdraws while requester 1 wins.
        next_ops(4'b0001, 100, 1'b0, 0);
        step();
        idle();
        vld[0] = 1'b1; rand_ops(0);
        vld[1] = 1'b1; rand_ops(1);
        drive();
        step();
        idle();
        drain();

        // Randomized traffic with random backpressure and occasional reset.
        mask = 4'hF;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(49) == 0) mask = N'($urandom_range(15));
            if ($urandom_range(299) == 0) begin
                ap_rst        = 1'b1;
                bus.rsp_ready = 1'b0;
                step();
                ap_rst        = 1'b0;
            end
            bus.rsp_ready = (int'($urandom_range(99)) < 70);
            next_ops(mask, 40, 1'b0, 5);
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
